// File: rtl/hid_inject_mux.sv
// hid_inject_mux: merges injected kbd/mouse HID reports with the proxied
// report stream, arbitrating only at packet boundaries.
module hid_inject_mux #(
    parameter int INJ_BURST_MAX = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      inject_kbd_report,
    input  logic             inject_kbd_valid,
    output logic             inject_kbd_ack,
    input  logic [39:0]      inject_mouse_report,
    input  logic             inject_mouse_valid,
    output logic             inject_mouse_ack,
    input  logic             mode_proxy,
    input  logic [7:0]       pt_data,
    input  logic             pt_valid,
    input  logic             pt_last,
    output logic             pt_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [1:0]       out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stat_inject_cnt,
    output logic [CNT_W-1:0] stat_drop_cnt
);

    localparam int BW = $clog2(INJ_BURST_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_KBD,
        SEND_MOUSE,
        PASS,
        DROP
    } state_t;

    state_t          state;
    logic [63:0]     shift;
    logic [2:0]      byte_idx;
    logic [BW-1:0]   burst_cnt;
    logic            pkt_end;
    logic            force_pt;

    // Last-byte detect for injected packets and the forced passthrough slot
    always_comb begin
        pkt_end  = ((state == SEND_KBD) && (byte_idx == 3'd7)) ||
                   ((state == SEND_MOUSE) && (byte_idx == 3'd4));
        force_pt = (burst_cnt == BW'(INJ_BURST_MAX)) && pt_valid;
    end

    // Stream outputs decoded from the current state; PASS is a straight wire-through
    always_comb begin
        out_data  = 8'd0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_src   = 2'd0;
        pt_ready  = 1'b0;
        unique case (state)
            SEND_KBD: begin
                out_valid = 1'b1;
                out_data  = shift[7:0];
                out_last  = pkt_end;
                out_src   = 2'd1;
            end
            SEND_MOUSE: begin
                out_valid = 1'b1;
                out_data  = shift[7:0];
                out_last  = pkt_end;
                out_src   = 2'd2;
            end
            PASS: begin
                out_valid = pt_valid;
                out_data  = pt_data;
                out_last  = pt_last;
                pt_ready  = out_ready;
            end
            DROP: begin
                pt_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Arbitration FSM, serialiser, burst limiter and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            shift            <= 64'd0;
            byte_idx         <= 3'd0;
            burst_cnt        <= '0;
            inject_kbd_ack   <= 1'b0;
            inject_mouse_ack <= 1'b0;
            stat_inject_cnt  <= '0;
            stat_drop_cnt    <= '0;
        end else begin
            inject_kbd_ack   <= 1'b0;
            inject_mouse_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (force_pt) begin
                        state <= mode_proxy ? PASS : DROP;
                    end else if (inject_kbd_valid) begin
                        shift          <= inject_kbd_report;
                        byte_idx       <= 3'd0;
                        inject_kbd_ack <= 1'b1;
                        state          <= SEND_KBD;
                    end else if (inject_mouse_valid) begin
                        shift            <= {24'd0, inject_mouse_report};
                        byte_idx         <= 3'd0;
                        inject_mouse_ack <= 1'b1;
                        state            <= SEND_MOUSE;
                    end else if (pt_valid) begin
                        state <= mode_proxy ? PASS : DROP;
                    end
                end
                SEND_KBD, SEND_MOUSE: begin
                    if (out_ready) begin
                        shift    <= shift >> 8;
                        byte_idx <= byte_idx + 3'd1;
                        if (pkt_end) begin
                            state <= IDLE;
                            if (burst_cnt != BW'(INJ_BURST_MAX))
                                burst_cnt <= burst_cnt + BW'(1);
                            if (stat_inject_cnt != '1)
                                stat_inject_cnt <= stat_inject_cnt + CNT_W'(1);
                        end
                    end
                end
                PASS: begin
                    if (pt_valid && out_ready && pt_last) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end
                end
                DROP: begin
                    if (pt_valid && pt_last) begin
                        state <= IDLE;
                        if (stat_drop_cnt != '1)
                            stat_drop_cnt <= stat_drop_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
